// File: rtl/sync_fifo.sv
// Single-clock parametrised FIFO with fill level, almost flags and sticky error flags.
// Read port is either first-word-fall-through (FWFT=1) or registered (FWFT=0).
module sync_fifo #(
    parameter int DATASIZE   = 8,
    parameter int ADDRSIZE   = 4,
    parameter int AFULL_THR  = (1 << ADDRSIZE) - 2,
    parameter int AEMPTY_THR = 2,
    parameter bit FWFT       = 1'b1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                flush_i,
    input  logic                winc_i,
    input  logic [DATASIZE-1:0] wdata_i,
    input  logic                rinc_i,
    output logic [DATASIZE-1:0] rdata_o,
    output logic                wfull_o,
    output logic                rempty_o,
    output logic                walmost_full_o,
    output logic                ralmost_empty_o,
    output logic [ADDRSIZE:0]   level_o,
    output logic                overflow_o,
    output logic                underflow_o
);

    localparam int DEPTH = 1 << ADDRSIZE;
    localparam logic [ADDRSIZE:0] DEPTH_L  = (ADDRSIZE + 1)'(DEPTH);
    localparam logic [ADDRSIZE:0] AFULL_L  = (ADDRSIZE + 1)'(AFULL_THR);
    localparam logic [ADDRSIZE:0] AEMPTY_L = (ADDRSIZE + 1)'(AEMPTY_THR);

    logic [DATASIZE-1:0] mem [DEPTH];

    logic [ADDRSIZE:0] wptr_q, wptr_d;
    logic [ADDRSIZE:0] rptr_q, rptr_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;
    logic [ADDRSIZE:0] level;
    logic              wacc, racc;

    // Flags come from registered pointers only, so no input-to-output paths.
    assign level           = wptr_q - rptr_q;
    assign level_o         = level;
    assign wfull_o         = (level == DEPTH_L);
    assign rempty_o        = (level == '0);
    assign walmost_full_o  = (level >= AFULL_L);
    assign ralmost_empty_o = (level <= AEMPTY_L);
    assign overflow_o      = overflow_q;
    assign underflow_o     = underflow_q;

    assign wacc = winc_i & ~wfull_o & ~flush_i;
    assign racc = rinc_i & ~rempty_o & ~flush_i;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        overflow_d  = overflow_q | (winc_i & wfull_o & ~flush_i);
        underflow_d = underflow_q | (rinc_i & rempty_o & ~flush_i);
        if (flush_i) begin
            wptr_d = '0;
            rptr_d = '0;
        end else begin
            if (wacc) wptr_d = wptr_q + 1'b1;
            if (racc) rptr_d = rptr_q + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // NOTE: the storage array is deliberately not reset; pointers alone define validity.
    always_ff @(posedge clk_i) begin
        if (wacc && !rst_i) begin
            mem[wptr_q[ADDRSIZE-1:0]] <= wdata_i;
        end
    end

    generate
        if (FWFT) begin : g_fwft
            assign rdata_o = mem[rptr_q[ADDRSIZE-1:0]];
        end else begin : g_reg
            logic [DATASIZE-1:0] rdata_q, rdata_d;

            always_comb begin
                rdata_d = rdata_q;
                if (racc) rdata_d = mem[rptr_q[ADDRSIZE-1:0]];
            end

            // Holds across flush and idle cycles; only a pop or reset changes it.
            always_ff @(posedge clk_i) begin
                if (rst_i) rdata_q <= '0;
                else       rdata_q <= rdata_d;
            end

            assign rdata_o = rdata_q;
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo.sv
// Directed self-checking bench: one FWFT and one registered-read instance share stimulus.
module tb_sync_fifo;

    logic       clk_i;
    logic       rst_i;
    logic       flush_i;
    logic       winc_i;
    logic [7:0] wdata_i;
    logic       rinc_i;

    logic [7:0] f_rdata, r_rdata;
    logic       f_full, f_empty, f_afull, f_aempty, f_ovf, f_unf;
    logic       r_full, r_empty, r_afull, r_aempty, r_ovf, r_unf;
    logic [4:0] f_level, r_level;

    int checks   = 0;
    int failures = 0;

    sync_fifo #(.DATASIZE(8), .ADDRSIZE(4), .AFULL_THR(14), .AEMPTY_THR(2), .FWFT(1'b1)) u_fwft (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .winc_i(winc_i), .wdata_i(wdata_i),
        .rinc_i(rinc_i), .rdata_o(f_rdata), .wfull_o(f_full), .rempty_o(f_empty),
        .walmost_full_o(f_afull), .ralmost_empty_o(f_aempty), .level_o(f_level),
        .overflow_o(f_ovf), .underflow_o(f_unf)
    );

    sync_fifo #(.DATASIZE(8), .ADDRSIZE(4), .AFULL_THR(14), .AEMPTY_THR(2), .FWFT(1'b0)) u_reg (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .winc_i(winc_i), .wdata_i(wdata_i),
        .rinc_i(rinc_i), .rdata_o(r_rdata), .wfull_o(r_full), .rempty_o(r_empty),
        .walmost_full_o(r_afull), .ralmost_empty_o(r_aempty), .level_o(r_level),
        .overflow_o(r_ovf), .underflow_o(r_unf)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        rst_i   = 1'b0;
        flush_i = 1'b0;
        winc_i  = 1'b0;
        rinc_i  = 1'b0;
        wdata_i = 8'h00;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
    endtask

    initial begin
        idle_inputs();
        winc_i = 1'b1;
        rinc_i = 1'b1;
        do_reset();
        idle_inputs();

        // Reset values
        check("rst_level", f_level, 0);
        check("rst_empty", f_empty, 1);
        check("rst_full", f_full, 0);
        check("rst_afull", f_afull, 0);
        check("rst_aempty", f_aempty, 1);
        check("rst_ovf", f_ovf, 0);
        check("rst_unf", f_unf, 0);
        check("rst_rdata_reg", r_rdata, 8'h00);
        check("rst_reg_level", r_level, 0);

        // Fill 0x00..0x0F
        for (int i = 0; i < 16; i++) begin
            winc_i  = 1'b1;
            wdata_i = 8'(i);
            step();
            check("fill_level", f_level, i + 1);
            check("fill_aempty", f_aempty, (i + 1 <= 2) ? 1 : 0);
            check("fill_afull", f_afull, (i + 1 >= 14) ? 1 : 0);
            check("fill_full", f_full, (i + 1 == 16) ? 1 : 0);
            check("fill_empty", f_empty, 0);
            if (i == 0) check("fwft_first_word", f_rdata, 8'h00);
        end
        wdata_i = 8'hFF;
        step();
        winc_i = 1'b0;
        check("ovf_17th", f_ovf, 1);
        check("ovf_level", f_level, 16);
        check("ovf_unf_clear", f_unf, 0);
        check("ovf_reg_inst", r_ovf, 1);

        // Drain 16 words
        for (int i = 0; i < 16; i++) begin
            check("drain_fwft", f_rdata, i);
            rinc_i = 1'b1;
            step();
            rinc_i = 1'b0;
            check("drain_reg", r_rdata, i);
            check("drain_level", f_level, 15 - i);
        end
        check("drain_empty", f_empty, 1);
        check("drain_unf_pre", f_unf, 0);
        rinc_i = 1'b1;
        step();
        rinc_i = 1'b0;
        check("unf_17th", f_unf, 1);
        check("unf_level", f_level, 0);
        check("unf_reg_hold", r_rdata, 8'h0F);

        // Registered read latency and hold
        winc_i = 1'b1; wdata_i = 8'hA5; step();
        wdata_i = 8'h3C; step();
        winc_i = 1'b0;
        check("reg_hold_prepop", r_rdata, 8'h0F);
        check("fwft_head_a5", f_rdata, 8'hA5);
        rinc_i = 1'b1; step(); rinc_i = 1'b0;
        check("reg_pop_a5", r_rdata, 8'hA5);
        for (int i = 0; i < 3; i++) begin
            step();
            check("reg_idle_hold", r_rdata, 8'hA5);
        end
        rinc_i = 1'b1; step(); rinc_i = 1'b0;
        check("reg_pop_3c", r_rdata, 8'h3C);
        check("reg_empty_again", f_empty, 1);

        // Sustained simultaneous read/write at level 5
        do_reset();
        check("rst2_ovf", f_ovf, 0);
        check("rst2_unf", f_unf, 0);
        check("rst2_rdata_reg", r_rdata, 8'h00);
        for (int i = 0; i < 5; i++) begin
            winc_i = 1'b1; wdata_i = 8'(8'h10 + i); step();
        end
        check("sim_level_start", f_level, 5);
        for (int i = 0; i < 40; i++) begin
            check("sim_fwft_head", f_rdata, 8'h10 + i);
            winc_i  = 1'b1;
            rinc_i  = 1'b1;
            wdata_i = 8'(8'h15 + i);
            step();
            check("sim_level", f_level, 5);
            check("sim_reg_data", r_rdata, 8'h10 + i);
        end
        idle_inputs();
        check("sim_ovf", f_ovf, 0);
        check("sim_unf", f_unf, 0);
        check("sim_head_after", f_rdata, 8'h38);

        // Full boundary: read accepted, write rejected
        for (int i = 0; i < 11; i++) begin
            winc_i = 1'b1; wdata_i = 8'(8'h50 + i); step();
        end
        winc_i = 1'b0;
        check("bnd_full", f_full, 1);
        winc_i = 1'b1; rinc_i = 1'b1; wdata_i = 8'hEE; step();
        idle_inputs();
        check("bnd_full_level", f_level, 15);
        check("bnd_full_ovf", f_ovf, 1);
        check("bnd_full_reg", r_rdata, 8'h38);
        check("bnd_full_head", f_rdata, 8'h39);

        // Empty boundary: write accepted, read rejected
        for (int i = 0; i < 15; i++) begin
            rinc_i = 1'b1; step();
        end
        rinc_i = 1'b0;
        check("bnd_drained", f_empty, 1);
        check("bnd_drained_reg", r_rdata, 8'h5A);
        check("bnd_unf_pre", f_unf, 0);
        winc_i = 1'b1; rinc_i = 1'b1; wdata_i = 8'h77; step();
        idle_inputs();
        check("bnd_empty_level", f_level, 1);
        check("bnd_empty_unf", f_unf, 1);
        check("bnd_empty_reg", r_rdata, 8'h5A);
        check("bnd_empty_head", f_rdata, 8'h77);

        // Flush with concurrent write at level 7
        for (int i = 0; i < 6; i++) begin
            winc_i = 1'b1; wdata_i = 8'(8'h60 + i); step();
        end
        winc_i = 1'b0;
        check("flush_pre_level", f_level, 7);
        flush_i = 1'b1; winc_i = 1'b1; wdata_i = 8'hEE; step();
        idle_inputs();
        check("flush_level", f_level, 0);
        check("flush_empty", f_empty, 1);
        check("flush_ovf_kept", f_ovf, 1);
        check("flush_unf_kept", f_unf, 1);
        check("flush_reg_hold", r_rdata, 8'h5A);

        // Reset clears sticky flags
        do_reset();
        check("rst3_ovf", f_ovf, 0);
        check("rst3_unf", f_unf, 0);
        check("rst3_level", f_level, 0);
        check("rst3_rdata_reg", r_rdata, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
